clk7m_phase_tracker: RTL

CLK7M_PHASE_TRACKER -- requirements
Module: clk7m_phase_tracker

---
 rtl/clk7m_phase_tracker.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/clk7m_phase_tracker.sv
// Recovers the phase of the 7.09 MHz reference inside its 6x PLL clock domain,
// qualifies period length and reports lock, slips and a saturating error count.
module clk7m_phase_tracker #(
  parameter int RATIO      = 6,
  parameter int LOCK_COUNT = 16
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       clk7m_in,
  input  logic       enable,
  output logic [2:0] phase,
  output logic       rise_stb,
  output logic       fall_stb,
  output logic       locked,
  output logic       slip,
  output logic [7:0] err_cnt
);

  localparam int PCW = $clog2(2 * RATIO + 1);
  localparam int GCW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT) : 1;

  localparam logic [2:0]     PHASE_LAST = 3'(RATIO - 1);
  localparam logic [PCW-1:0] PERIOD_ONE = PCW'(1);
  localparam logic [PCW-1:0] PERIOD_NOM = PCW'(RATIO);
  localparam logic [PCW-1:0] PERIOD_MAX = PCW'(2 * RATIO);
  localparam logic [GCW-1:0] GOOD_LAST  = GCW'(LOCK_COUNT - 1);
  localparam logic [7:0]     ERR_MAX    = 8'hFF;

  typedef enum logic [1:0] {
    HUNT   = 2'd0,
    TRACK  = 2'd1,
    LOCKED = 2'd2
  } state_t;

  logic           s1, s2, s3;
  logic           rise_det, fall_det;
  logic [PCW-1:0] period_cnt;
  logic           good_period, bad_period, timeout;

  state_t         state, state_next;
  logic [GCW-1:0] good_cnt, good_cnt_next;
  logic           slip_next;
  logic           err_hit;

  // Two-flop synchronizer for the asynchronous reference, then one history
  // flop so edges are detected on fully synchronized samples only.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= clk7m_in;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign rise_det = s2 & ~s3;
  assign fall_det = ~s2 & s3;

  // Phase and period measurement keep running regardless of enable.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      phase      <= '0;
      period_cnt <= '0;
    end else begin
      if (rise_det || (phase == PHASE_LAST)) begin
        phase <= '0;
      end else begin
        phase <= phase + 3'd1;
      end

      if (rise_det) begin
        period_cnt <= PERIOD_ONE;
      end else if (period_cnt != PERIOD_MAX) begin
        period_cnt <= period_cnt + PERIOD_ONE;
      end
    end
  end

  // A rise arriving on the saturated count is a bad period, not a timeout.
  assign good_period = rise_det && (period_cnt == PERIOD_NOM);
  assign bad_period  = rise_det && (period_cnt != PERIOD_NOM);
  assign timeout     = !rise_det && (period_cnt == PERIOD_MAX);

  // NOTE: every signal assigned in always_comb gets a default first, so no
  // path through the case leaves it unassigned and infers a latch.
  always_comb begin
    state_next    = state;
    good_cnt_next = good_cnt;
    slip_next     = 1'b0;
    err_hit       = 1'b0;

    if (!enable) begin
      state_next = HUNT;
    end else begin
      case (state)
        HUNT: begin
          if (rise_det) begin
            state_next    = TRACK;
            good_cnt_next = '0;
          end
        end

        TRACK: begin
          if (good_period) begin
            if (good_cnt == GOOD_LAST) begin
              state_next = LOCKED;
            end else begin
              good_cnt_next = good_cnt + GCW'(1);
            end
          end else if (bad_period) begin
            good_cnt_next = '0;
            err_hit       = 1'b1;
          end else if (timeout) begin
            state_next = HUNT;
            err_hit    = 1'b1;
          end
        end

        LOCKED: begin
          if (bad_period) begin
            state_next    = TRACK;
            good_cnt_next = '0;
            slip_next     = 1'b1;
            err_hit       = 1'b1;
          end else if (timeout) begin
            state_next = HUNT;
            slip_next  = 1'b1;
            err_hit    = 1'b1;
          end
        end

        default: begin
          state_next = HUNT;
        end
      endcase
    end
  end

  // locked follows the next state so it rises together with the completing rise_stb.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= HUNT;
      good_cnt <= '0;
      locked   <= 1'b0;
      slip     <= 1'b0;
      err_cnt  <= '0;
      rise_stb <= 1'b0;
      fall_stb <= 1'b0;
    end else begin
      state    <= state_next;
      good_cnt <= good_cnt_next;
      locked   <= (state_next == LOCKED);
      slip     <= slip_next;
      rise_stb <= rise_det & enable;
      fall_stb <= fall_det & enable;
      if (err_hit && (err_cnt != ERR_MAX)) begin
        err_cnt <= err_cnt + 8'd1;
      end
    end
  end

endmodule
